// File: rtl/mem_stage.sv
// Memory stage: pass-through for ALU ops, single-outstanding load/store over a req/gnt/rvalid bus.
// Latency 1 cycle for non-memory ops; memory ops stall upstream until completion, misalign or timeout.
module mem_stage #(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstl,
  input  logic [10:0] opcode_exe_2_mem_i,
  input  logic [4:0]  rd_exe_2_mem_i,
  input  logic [31:0] rd_data_exe_2_mem_i,
  input  logic [31:0] mem_data_i,
  input  logic        load_valid_i,
  input  logic        store_valid_i,
  input  logic [31:0] current_pc_mem_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [4:0]  rd_mem_2_wb_o,
  output logic [31:0] rd_data_mem_2_wb_o,
  output logic        wb_en_o,
  output logic [31:0] current_pc_mem_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CW = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DMEM_TIMEOUT - 1);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    funct3_q;
  logic [1:0]    addr_lo_q;
  logic [4:0]    rd_q;
  logic [31:0]   pc_q;

  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic        mem_op;
  logic        misaligned;
  logic        pass_wb;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        load_done;
  logic        store_done;
  logic        expired;
  logic        unused;

  assign funct3  = opcode_exe_2_mem_i[9:7];
  assign addr_lo = rd_data_exe_2_mem_i[1:0];
  assign mem_op  = load_valid_i | store_valid_i;
  assign pass_wb = (opcode_exe_2_mem_i[6:0] != OP_BRANCH) &&
                   (opcode_exe_2_mem_i[6:0] != OP_STORE) && (rd_exe_2_mem_i != 5'd0);
  assign unused  = opcode_exe_2_mem_i[10];

  // funct3[1:0] encodes the access size for both loads and stores
  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata      = mem_data_i;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{mem_data_i[7:0]}};
      end
      2'b01: begin
        misaligned = addr_lo[0];
        be         = 4'b0011 << addr_lo;
        wdata      = {2{mem_data_i[15:0]}};
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] w);
    logic [31:0] sh;
    logic [31:0] res;
    sh = w >> {lo, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b100:  res = {24'd0, sh[7:0]};
      3'b101:  res = {16'd0, sh[15:0]};
      default: res = w;
    endcase
    return res;
  endfunction

  assign dmem_req_o = (state == REQ);
  assign stall_o    = (state != IDLE);

  // gnt and rvalid together in REQ completes a load without visiting WAIT
  assign load_done  = ((state == REQ) && dmem_gnt_i && !dmem_we_o && dmem_rvalid_i) ||
                      ((state == WAIT) && dmem_rvalid_i);
  assign store_done = (state == REQ) && dmem_gnt_i && dmem_we_o;
  assign expired    = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      state              <= IDLE;
      cnt                <= '0;
      funct3_q           <= '0;
      addr_lo_q          <= '0;
      rd_q               <= '0;
      pc_q               <= '0;
      dmem_we_o          <= 1'b0;
      dmem_addr_o        <= '0;
      dmem_be_o          <= '0;
      dmem_wdata_o       <= '0;
      rd_mem_2_wb_o      <= '0;
      rd_data_mem_2_wb_o <= '0;
      wb_en_o            <= 1'b0;
      current_pc_mem_o   <= '0;
      misalign_o         <= 1'b0;
      bus_err_o          <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      wb_en_o    <= 1'b0;
      case (state)
        IDLE: begin
          rd_mem_2_wb_o      <= rd_exe_2_mem_i;
          rd_data_mem_2_wb_o <= rd_data_exe_2_mem_i;
          current_pc_mem_o   <= current_pc_mem_i;
          if (mem_op) begin
            if (misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              state        <= REQ;
              cnt          <= '0;
              dmem_we_o    <= store_valid_i;
              dmem_addr_o  <= {rd_data_exe_2_mem_i[31:2], 2'b00};
              dmem_be_o    <= be;
              dmem_wdata_o <= store_valid_i ? wdata : 32'd0;
              funct3_q     <= funct3;
              addr_lo_q    <= addr_lo;
              rd_q         <= rd_exe_2_mem_i;
              pc_q         <= current_pc_mem_i;
            end
          end else begin
            wb_en_o <= pass_wb;
          end
        end
        REQ, WAIT: begin
          if (load_done) begin
            state              <= IDLE;
            cnt                <= '0;
            wb_en_o            <= (rd_q != 5'd0);
            rd_mem_2_wb_o      <= rd_q;
            rd_data_mem_2_wb_o <= extract(funct3_q, addr_lo_q, dmem_rdata_i);
            current_pc_mem_o   <= pc_q;
          end else if (store_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (expired) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_err_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if ((state == REQ) && dmem_gnt_i) state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized plus directed bench for mem_stage against an arithmetic reference model.
module tb_mem_stage;
  localparam int T = 16;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic        clk = 1'b0;
  logic        rstl;
  logic [10:0] opcode_i;
  logic [4:0]  rd_i;
  logic [31:0] rd_data_i, mem_data_i, pc_i;
  logic        load_valid, store_valid;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [4:0]  rd_o;
  logic [31:0] rd_data_o, pc_o;
  logic        wb_en, stall, misalign, bus_err;

  int checks = 0;
  int errors = 0;
  int st;

  mem_stage #(.DMEM_TIMEOUT(T)) dut (
    .clk(clk), .rstl(rstl),
    .opcode_exe_2_mem_i(opcode_i), .rd_exe_2_mem_i(rd_i), .rd_data_exe_2_mem_i(rd_data_i),
    .mem_data_i(mem_data_i), .load_valid_i(load_valid), .store_valid_i(store_valid),
    .current_pc_mem_i(pc_i),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be),
    .dmem_wdata_o(dmem_wdata), .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i(dmem_rdata),
    .rd_mem_2_wb_o(rd_o), .rd_data_mem_2_wb_o(rd_data_o), .wb_en_o(wb_en),
    .current_pc_mem_o(pc_o), .stall_o(stall), .misalign_o(misalign), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    int unsigned v;
    int r;
    v = w / (32'd1 << (8 * (a % 4)));
    case (f3)
      3'b000: begin r = int'(v % 256);   if (r > 127)   r -= 256;   end
      3'b001: begin r = int'(v % 65536); if (r > 32767) r -= 65536; end
      3'b100: r = int'(v % 256);
      3'b101: r = int'(v % 65536);
      default: r = int'(w);
    endcase
    return 32'(r);
  endfunction

  task automatic randomize_upstream();
    opcode_i    = 11'($urandom);
    rd_i        = 5'($urandom);
    rd_data_i   = $urandom;
    mem_data_i  = $urandom;
    pc_i        = $urandom;
    load_valid  = 1'($urandom_range(0, 1));
    store_valid = 1'($urandom_range(0, 1));
  endtask

  // g: cycle index (from REQ entry) carrying gnt; rv_at: cycle index carrying rvalid for loads
  task automatic do_op(input logic [6:0] op7, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd, input int g,
                       input int rv_at, input logic [31:0] rdat, output int stalls);
    bit is_ld, is_st, mis;
    int n, done_at;
    logic [31:0] pc, exp_be, exp_wd, held_addr;
    is_ld  = (op7 == OP_LOAD);
    is_st  = (op7 == OP_STORE);
    n      = size_of(f3);
    mis    = (a % n) != 0;
    pc     = $urandom;
    stalls = 0;
    opcode_i = {1'b0, f3, op7}; rd_i = rd; rd_data_i = a; mem_data_i = sd; pc_i = pc;
    load_valid = is_ld; store_valid = is_st;
    dmem_gnt = 1'b0; dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    step();
    if (!(is_ld || is_st)) begin
      chk("pass_wb_en", wb_en, (op7 != OP_BRANCH) && (op7 != OP_STORE) && (rd != 0));
      chk("pass_data", rd_data_o, a);
      chk("pass_rd", rd_o, rd);
      chk("pass_pc", pc_o, pc);
      chk("pass_stall", stall, 0);
    end else if (mis) begin
      chk("mis_pulse", misalign, 1);
      chk("mis_req", dmem_req, 0);
      chk("mis_wb_en", wb_en, 0);
      chk("mis_stall", stall, 0);
      load_valid = 0; store_valid = 0; dmem_rvalid = 0;
      step();
      chk("mis_pulse_end", misalign, 0);
      chk("mis_req_after", dmem_req, 0);
    end else begin
      exp_be    = (n == 4) ? 32'hF : ((32'd1 << n) - 1) * (32'd1 << (a % 4));
      exp_wd    = sd * ((n == 1) ? 32'h01010101 : (n == 2) ? 32'h00010001 : 32'd1);
      held_addr = a - (a % 4);
      chk("cap_req", dmem_req, 1);
      chk("cap_stall", stall, 1);
      chk("cap_wb_en", wb_en, 0);
      chk("cap_addr", dmem_addr, held_addr);
      chk("cap_we", dmem_we, is_st);
      if (is_st) begin
        chk("cap_be", dmem_be, exp_be);
        chk("cap_wdata", dmem_wdata, exp_wd);
      end
      done_at = is_st ? g : rv_at;
      for (int k = 0; k < T; k++) begin
        if (stall) stalls++;
        randomize_upstream();
        dmem_gnt    = (k == g);
        dmem_rvalid = is_ld && ((k == rv_at) || (k < g && $urandom_range(0, 1) == 1));
        dmem_rdata  = (k == rv_at) ? rdat : $urandom;
        step();
        if (k == done_at) begin
          chk("done_stall", stall, 0);
          chk("done_bus_err", bus_err, 0);
          if (is_ld) begin
            chk("ld_wb_en", wb_en, rd != 0);
            chk("ld_data", rd_data_o, model_load(f3, a, rdat));
            chk("ld_rd", rd_o, rd);
            chk("ld_pc", pc_o, pc);
          end else begin
            chk("st_wb_en", wb_en, 0);
          end
          break;
        end
        if (k == T - 1) begin
          chk("to_bus_err", bus_err, 1);
          chk("to_stall", stall, 0);
          chk("to_req", dmem_req, 0);
          chk("to_wb_en", wb_en, 0);
          break;
        end
        chk("busy_stall", stall, 1);
        chk("busy_wb_en", wb_en, 0);
        chk("busy_req", dmem_req, k < g);
        if (k < g) chk("busy_addr", dmem_addr, held_addr);
      end
      load_valid = 0; store_valid = 0; dmem_gnt = 0; dmem_rvalid = 0;
      step();
      chk("cool_bus_err", bus_err, 0);
      chk("cool_stall", stall, 0);
    end
    load_valid = 0; store_valid = 0; dmem_gnt = 0; dmem_rvalid = 0;
  endtask

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] sd;
    logic [4:0]  rd;
    int g, rv, kind;

    rstl = 1'b0;
    opcode_i = '0; rd_i = '0; rd_data_i = '0; mem_data_i = '0; pc_i = '0;
    load_valid = 0; store_valid = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
    step();
    step();
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_data", rd_data_o, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_stall", stall, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_bus_err", bus_err, 0);
    rstl = 1'b1;

    do_op(OP_ALU, 3'b000, 32'h1234, 0, 5'd5, 0, 0, 0, st);
    do_op(OP_LOAD, 3'b000, 32'h103, 0, 5'd9, 1, 2, 32'h80FFFFFF, st);
    chk("lb_stall_cycles", st, 3);
    do_op(OP_STORE, 3'b001, 32'h202, 32'hBEEF, 5'd0, 0, 0, 0, st);
    do_op(OP_LOAD, 3'b010, 32'h101, 0, 5'd4, 0, 0, 0, st);
    do_op(OP_LOAD, 3'b101, 32'h104, 0, 5'd6, 0, 1000, 0, st);
    chk("to_stall_cycles", st, T);
    do_op(OP_LOAD, 3'b100, 32'h22, 0, 5'd3, 2, 2, 32'h00AB0000, st);
    do_op(OP_BRANCH, 3'b000, 32'h55, 0, 5'd8, 0, 0, 0, st);

    // reset while a load sits in WAIT
    opcode_i = {1'b0, 3'b010, OP_LOAD}; rd_i = 5'd11; rd_data_i = 32'h300; load_valid = 1;
    step();
    chk("rw_req", dmem_req, 1);
    load_valid = 0; dmem_gnt = 1;
    step();
    dmem_gnt = 0;
    chk("rw_wait_stall", stall, 1);
    #3 rstl = 1'b0;
    #1;
    chk("rw_rst_req", dmem_req, 0);
    chk("rw_rst_stall", stall, 0);
    chk("rw_rst_wb_en", wb_en, 0);
    @(posedge clk);
    #2 rstl = 1'b1;
    opcode_i = {1'b0, 3'b000, OP_ALU}; rd_i = 5'd7; rd_data_i = 32'hCAFE;
    dmem_rvalid = 1; dmem_rdata = 32'h5555AAAA;
    step();
    dmem_rvalid = 0;
    chk("rw_late_stall", stall, 0);
    chk("rw_late_wb_en", wb_en, 1);
    chk("rw_late_data", rd_data_o, 32'hCAFE);

    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 3);
      rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      g    = $urandom_range(0, 3);
      rv   = ($urandom_range(0, 7) == 0) ? 1000 : g + $urandom_range(0, 3);
      case (kind)
        0: begin op = ($urandom_range(0, 1) == 1) ? OP_ALU : OP_ALUI; f3 = 3'($urandom); end
        1: begin op = OP_BRANCH; f3 = 3'($urandom); end
        2: begin
          op = OP_LOAD;
          case ($urandom_range(0, 4))
            0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
        default: begin op = OP_STORE; f3 = 3'($urandom_range(0, 2)); end
      endcase
      sd = $urandom;
      if (size_of(f3) == 1) sd = sd % 256;
      else if (size_of(f3) == 2) sd = sd % 65536;
      do_op(op, f3, $urandom, sd, rd, g, rv, $urandom, st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter DMEM_TIMEOUT, default 16, meaning the maximum cycles spent in REQ+WAIT before a bus access is aborted.
REQ-002 The block SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rstl  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port opcode_exe_2_mem_i  in  11  {funct7[5],funct3,opcode} from execute.
REQ-005 The block SHALL have port rd_exe_2_mem_i  in  5  destination register.
REQ-006 The block SHALL have port rd_data_exe_2_mem_i  in  32  ALU result, or effective address for load/store.
REQ-007 The block SHALL have port mem_data_i  in  32  store data, already zero-extended to the access size.
REQ-008 The block SHALL have port load_valid_i  in  1  the current instruction is a load.
REQ-009 The block SHALL have port store_valid_i  in  1  the current instruction is a store.
REQ-010 The block SHALL have port current_pc_mem_i  in  32  PC of the current instruction.
REQ-011 The block SHALL have port dmem_req_o  out  1  bus request.
REQ-012 The block SHALL have port dmem_we_o  out  1  1 = write.
REQ-013 The block SHALL have port dmem_addr_o  out  32  word address, with bits [1:0] = 0.
REQ-014 The block SHALL have port dmem_be_o  out  4  byte enables.
REQ-015 The block SHALL have port dmem_wdata_o  out  32  write data, lane-replicated.
REQ-016 The block SHALL have port dmem_gnt_i  in  1  request accepted.
REQ-017 The block SHALL have port dmem_rvalid_i  in  1  read data valid.
REQ-018 The block SHALL have port dmem_rdata_i  in  32  read data.
REQ-019 The block SHALL have outputs rd_mem_2_wb_o (out 5), rd_data_mem_2_wb_o (out 32), wb_en_o (out 1) and current_pc_mem_o (out 32), all registered, to writeback.
REQ-020 The block SHALL have outputs stall_o, misalign_o and bus_err_o (each out 1); stall_o holds the upstream stages, and misalign_o and bus_err_o are 1-cycle error pulses.

Function
REQ-021 Non-memory instructions SHALL pass through with 1-cycle latency: rd, data and pc are registered, and wb_en_o=1 unless the opcode is branch (1100011) or store (0100011), or rd=0.
REQ-022 The FSM SHALL have states IDLE, REQ, WAIT and stall_o SHALL equal (state!=IDLE), combinationally.
REQ-023 In IDLE with load_valid_i or store_valid_i set and the access aligned, the block SHALL capture address, opcode, rd, pc and data, assert dmem_req_o, and move to REQ on the next edge; that cycle emits a bubble (wb_en_o=0).
REQ-024 In REQ, dmem_req_o and all bus fields SHALL be held stable until dmem_gnt_i=1; on gnt, a load moves to WAIT and a store moves to IDLE with wb_en_o=0.
REQ-025 In WAIT, on dmem_rvalid_i=1 the block SHALL return to IDLE and register the extracted load data with wb_en_o=(rd!=0).
REQ-026 Load extraction SHALL select the byte or half by address[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW uses the whole word.
REQ-027 Store byte enables SHALL be: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; wdata replicates the byte ×4 for SB and the half ×2 for SH.
REQ-028 Misaligned accesses (LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1) SHALL issue no bus request, pulse misalign_o for 1 cycle, give wb_en_o=0, and keep the FSM in IDLE.
REQ-029 A cycle counter SHALL count from entry into REQ; when it reaches DMEM_TIMEOUT without completion, the block SHALL drop dmem_req_o, pulse bus_err_o, return to IDLE, and give wb_en_o=0.
REQ-030 Inputs SHALL be ignored while state!=IDLE, because upstream holds them under stall_o.
REQ-031 If gnt and rvalid arrive in the same cycle in REQ for a load, the block SHALL complete directly to IDLE with the data.
REQ-032 A dmem_rvalid_i that arrives in IDLE or REQ without a prior gnt SHALL be ignored.

Reset
REQ-033 While rstl=0, all outputs SHALL be 0, the FSM SHALL be IDLE and the counter 0; reset mid-access SHALL drop dmem_req_o immediately and discard the pending access.

Verification
REQ-034 The bench SHALL check: ADD pass-through with rd=5, data 0x1234 -> next cycle wb_en_o=1, rd_data=0x1234, stall_o=0.
REQ-035 The bench SHALL check: LB at addr 0x103, gnt after 2 cycles, rdata 0x80FFFFFF -> rd_data=0xFFFFFF80, stall_o high for 3 cycles.
REQ-036 The bench SHALL check: SH at addr 0x202 with data 0xBEEF -> be=4'b1100, wdata=0xBEEFBEEF, addr=0x200, wb_en_o=0.
REQ-037 The bench SHALL check: LW at addr 0x101 -> misalign_o pulse, dmem_req_o never asserted.
REQ-038 The bench SHALL check: LHU with no rvalid -> bus_err_o pulses DMEM_TIMEOUT cycles after entering REQ, then state is IDLE.
REQ-039 The bench SHALL check: rstl low while in WAIT -> dmem_req_o=0 and stall_o=0 asynchronously, and a later rvalid is ignored.
